interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//  Consumes the ICW/OCW write strobes and latched data produced by the host read/write control stage.
//  Holds IRR/ISR/IMR, resolves fixed priority (IR0 highest) and raises INT.
//  Runs the 8086-mode two-pulse INTA cycle and drives the vector byte.
//  Exports irr/isr/imr back upstream for status read-back.
// PARAMETERS
//  NUM_IR      8     interrupt request lines; vector math fixed to 8
//  SPUR_LEVEL  7     IR level reported on a spurious acknowledge
// PORTS
//  clk      in   1  system clock; all state on posedge
//  rst_n    in   1  asynchronous, active-low reset
//  ir       in   8  interrupt request pins, already synchronised to clk
//  inta_n   in   1  CPU acknowledge, synchronised to clk, active low
//  din      in   8  data byte accompanying a write strobe
//  icw_wr   in   4  one-cycle strobes: [0]=ICW1 [1]=ICW2 [2]=ICW3 [3]=ICW4; at most one bit set
//  ocw_wr   in   3  one-cycle strobes: [0]=OCW1 [1]=OCW2 [2]=OCW3; at most one bit set
//  int_out  out  1  interrupt request to CPU, active high
//  dout     out  8  vector byte
//  dout_en  out  1  dout valid / bus drive enable
//  irr      out  8  interrupt request register
//  isr      out  8  in-service register
//  imr      out  8  interrupt mask register
// BEHAVIOUR
//  Reset values:
//   - int_out=0, dout=0, dout_en=0, irr=0, isr=0, imr=8'hFF
//   - vec_base=0, ltim=0, aeoi=0, init_done=0, state=IDLE
//  ICW1 write (any cycle, including mid-INTA):
//   - latch ltim=din[3], sngl=din[1], ic4=din[0]
//   - clear isr and imr; state->IDLE; init_done=0; dout_en=0
//   - ICW1 overrides any INTA edge in the same cycle
//  ICW initialisation sequence:
//   - ICW2: vec_base=din[7:3]
//   - ICW3: accepted and ignored
//   - ICW4: aeoi=din[1]
//   - init_done=1 on the cycle of the last expected ICW: ICW2 if sngl&~ic4, ICW3 if ~ic4, else ICW4
//  OCW handling:
//   - OCW1: imr=din
//   - OCW2 din[7:5]=001 (non-specific EOI): clear highest-priority set isr bit
//   - OCW2 din[7:5]=011 (specific EOI): clear isr[din[2:0]]
//   - all other OCW2 codes, and OCW3, are no-ops here
//  IRR update:
//   - ltim=1 (level mode): irr=ir each cycle
//   - ltim=0 (edge mode): set irr bit on a 0->1 edge of ir (previous sample held in a register)
//   - edge mode: clear irr bit when that ir line is low
//   - either mode: irr bit cleared on first-INTA acceptance
//  Priority and INT:
//   - req = irr & ~imr; hp = lowest set index of req
//   - int_out=1 (registered, 1-cycle latency) when init_done, state==IDLE, req!=0 and
//     hp ranks above every set isr bit
//   - int_out drops on the cycle following the first INTA falling edge
//  INTA FSM (transitions on inta_n falling-edge detect):
//   - IDLE->ACK1: on 1st edge, latch lvl=hp; set isr[hp], clear irr[hp].
//     If req==0 (spurious): lvl=SPUR_LEVEL, isr untouched.
//   - ACK1->ACK2: on 2nd edge: dout={vec_base,lvl}, dout_en=1.
//   - ACK2->IDLE: when inta_n rises: dout_en=0. If aeoi and not spurious, clear isr[lvl].
//   - INTA edge in IDLE while int_out=0 still enters ACK1 (spurious path).
//  Simultaneous events:
//   - EOI in the same cycle as 1st-INTA: EOI clears first, then isr[hp] is set
//   - OCW1 in the same cycle as 1st-INTA: old imr used for resolution
// STRUCTURE
//  - pic_pkg: state enum {IDLE,ACK1,ACK2}; OCW2 codes EOI_NS=3'b001, EOI_SP=3'b011; ICW bit indices
//  - Sub-module priority_resolver: 8-bit find-first-set -> {valid, idx[2:0]}; instanced for req and isr
// TESTING
//  1 Init ICW1=8'h13, ICW2=8'h20, ICW4=8'h01; pulse ir[3] -> int_out=1; two INTA -> dout=8'h23, dout_en=1, isr=8'h08
//  2 isr=8'h08 then ir[5] raised -> int_out stays 0; raise ir[1] -> int_out=1; OCW2=8'h20 after ack -> isr[1] cleared first
//  3 ICW4=8'h03 (AEOI), ir[6] ack -> dout=8'h26; isr=0 after inta_n rises
//  4 OCW1=8'hFF, ir[2] high -> int_out=0; OCW1=8'h00 -> int_out=1 within 2 cycles
//  5 Spurious: INTA pair with irr=0 -> dout=8'h27, isr unchanged
//  6 ICW1 between INTA pulses -> state IDLE, dout_en=0, isr=0, imr=0; async rst_n low mid-ACK2 -> all reset values

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and encodings for the interrupt sequencer.
package pic_pkg;

    // Acknowledge-cycle state of the sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } state_t;

    // OCW2 command codes carried in din[7:5].
    localparam logic [2:0] EOI_NS = 3'b001;
    localparam logic [2:0] EOI_SP = 3'b011;

    // Positions of the individual strobes in icw_wr / ocw_wr.
    localparam int ICW1_IDX = 0;
    localparam int ICW2_IDX = 1;
    localparam int ICW3_IDX = 2;
    localparam int ICW4_IDX = 3;
    localparam int OCW1_IDX = 0;
    localparam int OCW2_IDX = 1;
    localparam int OCW3_IDX = 2;

    // Field positions inside the ICW data bytes.
    localparam int IC4_BIT  = 0;
    localparam int SNGL_BIT = 1;
    localparam int LTIM_BIT = 3;
    localparam int AEOI_BIT = 1;

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Host/CPU-facing signal bundle of the interrupt sequencer.
interface interrupt_sequencer_if;
    logic [7:0] ir;
    logic       inta_n;
    logic [7:0] din;
    logic [3:0] icw_wr;
    logic [2:0] ocw_wr;
    logic       int_out;
    logic [7:0] dout;
    logic       dout_en;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] imr;

    modport master (
        output ir, inta_n, din, icw_wr, ocw_wr,
        input  int_out, dout, dout_en, irr, isr, imr
    );

    modport slave (
        input  ir, inta_n, din, icw_wr, ocw_wr,
        output int_out, dout, dout_en, irr, isr, imr
    );
endinterface

// File: rtl/priority_resolver.sv
// Fixed-priority find-first-set: bit 0 is the highest priority.
module priority_resolver (
    input  logic [7:0] vec,
    output logic       valid,
    output logic [2:0] idx
);

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                idx   = i[2:0];
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// 8259-style interrupt sequencer: request/service/mask registers,
// fixed priority resolution and the 8086-mode two-pulse acknowledge.
import pic_pkg::*;

module interrupt_sequencer #(
    parameter int NUM_IR     = 8,
    parameter int SPUR_LEVEL = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    interrupt_sequencer_if.slave  bus
);

    state_t              state, state_nxt;
    logic [NUM_IR-1:0]   irr_q, irr_nxt;
    logic [NUM_IR-1:0]   isr_q, isr_nxt;
    logic [NUM_IR-1:0]   imr_q, imr_nxt;
    logic [NUM_IR-1:0]   ir_prev;
    logic [4:0]          vec_base_q, vec_base_nxt;
    logic                ltim_q, ltim_nxt;
    logic                sngl_q, sngl_nxt;
    logic                ic4_q, ic4_nxt;
    logic                aeoi_q, aeoi_nxt;
    logic                init_done_q, init_done_nxt;
    logic                spur_q, spur_nxt;
    logic [2:0]          lvl_q, lvl_nxt;
    logic                int_q, int_nxt;
    logic [7:0]          dout_q, dout_nxt;
    logic                dout_en_q, dout_en_nxt;
    logic                inta_prev;

    logic [NUM_IR-1:0]   req;
    logic                req_v, isr_v;
    logic [2:0]          req_idx, isr_idx;
    logic                inta_fall, inta_rise, icw1;
    logic                unused_ocw3;

    assign req       = irr_q & ~imr_q;
    assign inta_fall = inta_prev & ~bus.inta_n;
    assign inta_rise = ~inta_prev & bus.inta_n;
    assign icw1      = bus.icw_wr[ICW1_IDX];

    // OCW3 (read-select / poll) has no effect inside this block.
    assign unused_ocw3 = bus.ocw_wr[OCW3_IDX];

    priority_resolver u_req_res (
        .vec   (req),
        .valid (req_v),
        .idx   (req_idx)
    );

    priority_resolver u_isr_res (
        .vec   (isr_q),
        .valid (isr_v),
        .idx   (isr_idx)
    );

    // Register all sequencer state; reset leaves every line masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            irr_q       <= '0;
            isr_q       <= '0;
            imr_q       <= '1;
            ir_prev     <= '0;
            vec_base_q  <= '0;
            ltim_q      <= 1'b0;
            sngl_q      <= 1'b0;
            ic4_q       <= 1'b0;
            aeoi_q      <= 1'b0;
            init_done_q <= 1'b0;
            spur_q      <= 1'b0;
            lvl_q       <= '0;
            int_q       <= 1'b0;
            dout_q      <= '0;
            dout_en_q   <= 1'b0;
            inta_prev   <= 1'b1;
        end else begin
            state       <= state_nxt;
            irr_q       <= irr_nxt;
            isr_q       <= isr_nxt;
            imr_q       <= imr_nxt;
            ir_prev     <= bus.ir;
            vec_base_q  <= vec_base_nxt;
            ltim_q      <= ltim_nxt;
            sngl_q      <= sngl_nxt;
            ic4_q       <= ic4_nxt;
            aeoi_q      <= aeoi_nxt;
            init_done_q <= init_done_nxt;
            spur_q      <= spur_nxt;
            lvl_q       <= lvl_nxt;
            int_q       <= int_nxt;
            dout_q      <= dout_nxt;
            dout_en_q   <= dout_en_nxt;
            inta_prev   <= bus.inta_n;
        end
    end

    // Next-state: configuration writes, EOI, IRR sampling and the INTA sequence.
    // EOI is applied before the first-INTA set so both can land in one cycle.
    always_comb begin
        state_nxt     = state;
        isr_nxt       = isr_q;
        imr_nxt       = imr_q;
        vec_base_nxt  = vec_base_q;
        ltim_nxt      = ltim_q;
        sngl_nxt      = sngl_q;
        ic4_nxt       = ic4_q;
        aeoi_nxt      = aeoi_q;
        init_done_nxt = init_done_q;
        spur_nxt      = spur_q;
        lvl_nxt       = lvl_q;
        dout_nxt      = dout_q;
        dout_en_nxt   = dout_en_q;

        if (ltim_q) begin
            irr_nxt = bus.ir;
        end else begin
            irr_nxt = (irr_q | (bus.ir & ~ir_prev)) & bus.ir;
        end

        if (icw1) begin
            ltim_nxt      = bus.din[LTIM_BIT];
            sngl_nxt      = bus.din[SNGL_BIT];
            ic4_nxt       = bus.din[IC4_BIT];
            isr_nxt       = '0;
            imr_nxt       = '0;
            state_nxt     = IDLE;
            init_done_nxt = 1'b0;
            dout_en_nxt   = 1'b0;
        end else begin
            if (bus.icw_wr[ICW2_IDX]) begin
                vec_base_nxt = bus.din[7:3];
                if (sngl_q && !ic4_q) init_done_nxt = 1'b1;
            end
            if (bus.icw_wr[ICW3_IDX] && !ic4_q) begin
                init_done_nxt = 1'b1;
            end
            if (bus.icw_wr[ICW4_IDX]) begin
                aeoi_nxt      = bus.din[AEOI_BIT];
                init_done_nxt = 1'b1;
            end

            if (bus.ocw_wr[OCW1_IDX]) begin
                imr_nxt = bus.din;
            end
            if (bus.ocw_wr[OCW2_IDX]) begin
                if (bus.din[7:5] == EOI_NS) begin
                    if (isr_v) isr_nxt[isr_idx] = 1'b0;
                end else if (bus.din[7:5] == EOI_SP) begin
                    isr_nxt[bus.din[2:0]] = 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (inta_fall) begin
                        state_nxt = ACK1;
                        if (req_v) begin
                            lvl_nxt           = req_idx;
                            spur_nxt          = 1'b0;
                            isr_nxt[req_idx]  = 1'b1;
                            irr_nxt[req_idx]  = 1'b0;
                        end else begin
                            lvl_nxt  = 3'(SPUR_LEVEL);
                            spur_nxt = 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (inta_fall) begin
                        state_nxt   = ACK2;
                        dout_nxt    = {vec_base_q, lvl_q};
                        dout_en_nxt = 1'b1;
                    end
                end
                ACK2: begin
                    if (inta_rise) begin
                        state_nxt   = IDLE;
                        dout_en_nxt = 1'b0;
                        if (aeoi_q && !spur_q) isr_nxt[lvl_q] = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Request only when idle and the winner outranks everything in service.
        int_nxt = init_done_q && (state == IDLE) && !inta_fall && !icw1 &&
                  req_v && (!isr_v || (req_idx < isr_idx));
    end

    assign bus.int_out = int_q;
    assign bus.dout    = dout_q;
    assign bus.dout_en = dout_en_q;
    assign bus.irr     = irr_q;
    assign bus.isr     = isr_q;
    assign bus.imr     = imr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed-vector bench for interrupt_sequencer: one record per clock cycle.
module tb_interrupt_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    interrupt_sequencer_if bus ();

    interrupt_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] icw;
        logic [2:0] ocw;
        logic [7:0] din;
        logic [7:0] ir;
        logic       inta_n;
        logic       e_int;
        logic       e_en;
        logic [7:0] e_dout;
        logic [7:0] e_isr;
        logic [7:0] e_irr;
        logic [7:0] e_imr;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] icw, logic [2:0] ocw, logic [7:0] din,
                                logic [7:0] ir, logic inta_n, logic e_int, logic e_en,
                                logic [7:0] e_dout, logic [7:0] e_isr,
                                logic [7:0] e_irr, logic [7:0] e_imr);
        vec_t v;
        v.icw = icw; v.ocw = ocw; v.din = din; v.ir = ir; v.inta_n = inta_n;
        v.e_int = e_int; v.e_en = e_en; v.e_dout = e_dout;
        v.e_isr = e_isr; v.e_irr = e_irr; v.e_imr = e_imr;
        return v;
    endfunction

    task automatic chk(string name, int id, logic [7:0] got, logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, id, got, exp);
    endtask

    task automatic check_outs(int id, logic e_int, logic e_en, logic [7:0] e_dout,
                              logic [7:0] e_isr, logic [7:0] e_irr, logic [7:0] e_imr);
        chk("int_out", id, {7'd0, bus.int_out}, {7'd0, e_int});
        chk("dout_en", id, {7'd0, bus.dout_en}, {7'd0, e_en});
        chk("dout",    id, bus.dout, e_dout);
        chk("isr",     id, bus.isr,  e_isr);
        chk("irr",     id, bus.irr,  e_irr);
        chk("imr",     id, bus.imr,  e_imr);
    endtask

    task automatic apply(vec_t v, int id);
        bus.icw_wr = v.icw;
        bus.ocw_wr = v.ocw;
        bus.din    = v.din;
        bus.ir     = v.ir;
        bus.inta_n = v.inta_n;
        @(posedge clk);
        #1;
        check_outs(id, v.e_int, v.e_en, v.e_dout, v.e_isr, v.e_irr, v.e_imr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // icw ocw din ir inta | int en dout isr irr imr
        // Init, single request on IR3, full acknowledge.
        vecs.push_back(mk(4'h1, 3'h0, 8'h13, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(4'h2, 3'h0, 8'h20, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(4'h8, 3'h0, 8'h01, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h08, 1, 0, 0, 8'h00, 8'h00, 8'h08, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h08, 1, 1, 0, 8'h00, 8'h00, 8'h08, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h08, 0, 0, 0, 8'h00, 8'h08, 8'h00, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h08, 1, 0, 0, 8'h00, 8'h08, 8'h00, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h08, 0, 0, 1, 8'h23, 8'h08, 8'h00, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h08, 1, 0, 0, 8'h23, 8'h08, 8'h00, 8'h00));
        // Lower-priority IR5 blocked by IR3 in service; IR1 preempts.
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h28, 1, 0, 0, 8'h23, 8'h08, 8'h20, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h28, 1, 0, 0, 8'h23, 8'h08, 8'h20, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h2A, 1, 0, 0, 8'h23, 8'h08, 8'h22, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h2A, 1, 1, 0, 8'h23, 8'h08, 8'h22, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h2A, 0, 0, 0, 8'h23, 8'h0A, 8'h20, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h2A, 1, 0, 0, 8'h23, 8'h0A, 8'h20, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h2A, 0, 0, 1, 8'h21, 8'h0A, 8'h20, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h2A, 1, 0, 0, 8'h21, 8'h0A, 8'h20, 8'h00));
        // Everything masked: spurious acknowledge leaves isr/irr alone.
        vecs.push_back(mk(4'h0, 3'h1, 8'hFF, 8'h2A, 1, 0, 0, 8'h21, 8'h0A, 8'h20, 8'hFF));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h2A, 0, 0, 0, 8'h21, 8'h0A, 8'h20, 8'hFF));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h2A, 1, 0, 0, 8'h21, 8'h0A, 8'h20, 8'hFF));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h2A, 0, 0, 1, 8'h27, 8'h0A, 8'h20, 8'hFF));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h2A, 1, 0, 0, 8'h27, 8'h0A, 8'h20, 8'hFF));
        // Unmask, non-specific EOI clears IR1 first, specific EOI clears IR3.
        vecs.push_back(mk(4'h0, 3'h1, 8'h00, 8'h2A, 1, 0, 0, 8'h27, 8'h0A, 8'h20, 8'h00));
        vecs.push_back(mk(4'h0, 3'h2, 8'h20, 8'h2A, 1, 0, 0, 8'h27, 8'h08, 8'h20, 8'h00));
        vecs.push_back(mk(4'h0, 3'h2, 8'h63, 8'h2A, 1, 0, 0, 8'h27, 8'h00, 8'h20, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h2A, 1, 1, 0, 8'h27, 8'h00, 8'h20, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h00, 1, 1, 0, 8'h27, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h00, 1, 0, 0, 8'h27, 8'h00, 8'h00, 8'h00));
        // Re-init with AEOI, acknowledge IR6.
        vecs.push_back(mk(4'h1, 3'h0, 8'h13, 8'h00, 1, 0, 0, 8'h27, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(4'h2, 3'h0, 8'h20, 8'h00, 1, 0, 0, 8'h27, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(4'h8, 3'h0, 8'h03, 8'h00, 1, 0, 0, 8'h27, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h40, 1, 0, 0, 8'h27, 8'h00, 8'h40, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h40, 1, 1, 0, 8'h27, 8'h00, 8'h40, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h40, 0, 0, 0, 8'h27, 8'h40, 8'h00, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h40, 1, 0, 0, 8'h27, 8'h40, 8'h00, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h40, 0, 0, 1, 8'h26, 8'h40, 8'h00, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h40, 1, 0, 0, 8'h26, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h00, 1, 0, 0, 8'h26, 8'h00, 8'h00, 8'h00));
        // Mask IR2, then unmask: old mask is used in the OCW1 cycle.
        vecs.push_back(mk(4'h0, 3'h1, 8'hFF, 8'h00, 1, 0, 0, 8'h26, 8'h00, 8'h00, 8'hFF));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h04, 1, 0, 0, 8'h26, 8'h00, 8'h04, 8'hFF));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h04, 1, 0, 0, 8'h26, 8'h00, 8'h04, 8'hFF));
        vecs.push_back(mk(4'h0, 3'h1, 8'h00, 8'h04, 1, 0, 0, 8'h26, 8'h00, 8'h04, 8'h00));
        vecs.push_back(mk(4'h0, 3'h0, 8'h00, 8'h04, 1, 1, 0, 8'h26, 8'h00, 8'h04, 8'h00));

        bus.icw_wr = '0;
        bus.ocw_wr = '0;
        bus.din    = '0;
        bus.ir     = '0;
        bus.inta_n = 1'b1;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_outs(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFF);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i + 1);
        end

        // ICW1 between the two INTA pulses aborts the cycle; the next
        // falling edge must start a fresh (spurious) first pulse.
        apply(mk(4'h0, 3'h0, 8'h00, 8'h04, 0, 0, 0, 8'h26, 8'h04, 8'h00, 8'h00), 101);
        apply(mk(4'h0, 3'h0, 8'h00, 8'h04, 1, 0, 0, 8'h26, 8'h04, 8'h00, 8'h00), 102);
        apply(mk(4'h1, 3'h0, 8'h13, 8'h04, 1, 0, 0, 8'h26, 8'h00, 8'h00, 8'h00), 103);
        apply(mk(4'h0, 3'h0, 8'h00, 8'h04, 0, 0, 0, 8'h26, 8'h00, 8'h00, 8'h00), 104);
        apply(mk(4'h0, 3'h0, 8'h00, 8'h04, 1, 0, 0, 8'h26, 8'h00, 8'h00, 8'h00), 105);
        apply(mk(4'h0, 3'h0, 8'h00, 8'h04, 0, 0, 1, 8'h27, 8'h00, 8'h00, 8'h00), 106);

        // Asynchronous reset while the vector is on the bus.
        #2 rst_n = 1'b0;
        #1 check_outs(107, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFF);
        bus.inta_n = 1'b1;
        bus.ir     = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Level mode, single/no-ICW4 init completes on ICW2.
        apply(mk(4'h1, 3'h0, 8'h1A, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00), 111);
        apply(mk(4'h2, 3'h0, 8'h20, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00), 112);
        apply(mk(4'h0, 3'h0, 8'h00, 8'h10, 1, 0, 0, 8'h00, 8'h00, 8'h10, 8'h00), 113);
        apply(mk(4'h0, 3'h0, 8'h00, 8'h10, 1, 1, 0, 8'h00, 8'h00, 8'h10, 8'h00), 114);
        apply(mk(4'h0, 3'h0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00), 115);
        apply(mk(4'h0, 3'h0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00), 116);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
